cam_port_scheduler: RTL and testbench

- Shares one CAM search/write command port among N requesters, each with valid/ready handshake and multi-beat transactions.
- Round-robin choice of owner, with optional extra weight for requester 0. The owner stays locked until its last beat.
- Output has a one-entry register stage. Sits between the per-client command queues and the CAM core command input.

---
 rtl/cam_sched_pkg.sv | 23 ++
 rtl/cam_rr_pick.sv | 24 ++
 rtl/cam_port_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_cam_port_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_sched_pkg.sv
// Shared types and constants for the CAM command-port scheduler.
// Used by cam_port_scheduler and cam_rr_pick.
package cam_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } cam_state_e;

    localparam int STAT_W = 16;

    function automatic int cam_clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cam_rr_pick.sv
// Combinational round-robin pick: first requester at or above the one-hot
// pointer, wrapping, via the double-width mask-subtract trick.
module cam_rr_pick
    import cam_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] grant
);

    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] dbl_gnt;

    // Subtracting the pointer clears the first set bit at or above it; a
    // borrow past the top of the low half lands on the wrapped requester.
    always_comb begin
        dbl_req = {req, req};
        dbl_gnt = dbl_req & ~(dbl_req - {{N{1'b0}}, ptr});
        grant   = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
    end

endmodule

// File: rtl/cam_port_scheduler.sv
// Shares one CAM command port among N requesters; owner locked until its last beat.
// Optional per-requester transaction counters with macro CAM_SCHED_STATS_EN.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no owner; arbitrate among valid requesters this cycle
//   ST_LOCK | owner_q holds the port until its last beat is accepted
module cam_port_scheduler
    import cam_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 64,
    parameter int W  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              req_valid,
    input  logic [N-1:0]              req_last,
    input  logic [N*DW-1:0]           req_data,
    output logic [N-1:0]              req_ready,
    output logic                      out_valid,
    output logic [DW-1:0]             out_data,
    output logic                      out_last,
    output logic [cam_clog2(N)-1:0]   out_src,
    input  logic                      out_ready,
`ifdef CAM_SCHED_STATS_EN
    input  logic                      stat_clr,
    output logic [N*STAT_W-1:0]       stat_txn,
`endif
    output logic                      busy
);

    localparam int SW  = cam_clog2(N);
    localparam int WCW = cam_clog2((W > 1) ? W : 2);

    cam_state_e     state_q, state_d;
    logic [SW-1:0]  owner_q, owner_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic           out_last_q, out_last_d;
    logic [SW-1:0]  out_src_q, out_src_d;

    logic [N-1:0]   grant;
    logic [SW-1:0]  grant_idx;
    logic [N-1:0]   req_ready_c;
    logic           accept;
    logic           txn_done;
    logic [DW-1:0]  beat_data [N];

    for (genvar g = 0; g < N; g++) begin : g_beat
        assign beat_data[g] = req_data[g*DW +: DW];
    end

    cam_rr_pick #(.N(N)) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = SW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        wcnt_d      = wcnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        req_ready_c = '0;
        accept      = 1'b0;
        txn_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    owner_d = grant_idx;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                req_ready_c[owner_q] = !out_valid_q || out_ready;
                accept   = req_valid[owner_q] && req_ready_c[owner_q];
                txn_done = accept && req_last[owner_q];
                if (txn_done) begin
                    state_d = ST_IDLE;
                    // Requester 0 may keep the pointer for W transactions in a row.
                    if (W > 1 && owner_q == '0 && wcnt_q != WCW'(W - 1)) begin
                        wcnt_d = WCW'(wcnt_q + 1'b1);
                    end else begin
                        wcnt_d = '0;
                        ptr_d  = (int'(owner_q) == N - 1) ? N'(1)
                                                          : (N'(1) << (int'(owner_q) + 1));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_data[owner_q];
            out_last_d  = req_last[owner_q];
            out_src_d   = owner_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            ptr_q       <= N'(1);
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign req_ready = req_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q == ST_LOCK) || out_valid_q;

`ifdef CAM_SCHED_STATS_EN
    logic [STAT_W-1:0] stat_q [N];
    logic [STAT_W-1:0] stat_d [N];

    // Clear takes priority over a completion in the same cycle.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            stat_d[i] = stat_q[i];
            if (stat_clr) begin
                stat_d[i] = '0;
            end else if (txn_done && owner_q == SW'(i) && stat_q[i] != '1) begin
                stat_d[i] = stat_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_stat
        assign stat_txn[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_cam_port_scheduler.sv
// Self-checking bench for cam_port_scheduler: directed vector table, hand
// sequences for multi-cycle corners, and random traffic against a reference model.
module tb_cam_port_scheduler;

    localparam int N  = 4;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            out_valid, out_last, out_ready, busy;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;

    logic            w_rst_n;
    logic [N-1:0]    w_req_valid, w_req_last, w_req_ready;
    logic [N*DW-1:0] w_req_data;
    logic            w_out_valid, w_out_last, w_out_ready, w_busy;
    logic [DW-1:0]   w_out_data;
    logic [1:0]      w_out_src;

`ifdef CAM_SCHED_STATS_EN
    logic            stat_clr, w_stat_clr;
    logic [N*16-1:0] stat_txn, w_stat_txn;
`endif

    always #5 clk = ~clk;

    cam_port_scheduler #(.N(N), .DW(DW), .W(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_src(out_src), .out_ready(out_ready),
`ifdef CAM_SCHED_STATS_EN
        .stat_clr(stat_clr), .stat_txn(stat_txn),
`endif
        .busy(busy)
    );

    cam_port_scheduler #(.N(N), .DW(DW), .W(3)) dut_w (
        .clk(clk), .rst_n(w_rst_n),
        .req_valid(w_req_valid), .req_last(w_req_last), .req_data(w_req_data),
        .req_ready(w_req_ready),
        .out_valid(w_out_valid), .out_data(w_out_data), .out_last(w_out_last),
        .out_src(w_out_src), .out_ready(w_out_ready),
`ifdef CAM_SCHED_STATS_EN
        .stat_clr(w_stat_clr), .stat_txn(w_stat_txn),
`endif
        .busy(w_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: transaction-level view of ownership and the output slot.
    int          m_ptr, m_owner;
    bit          m_locked, m_ov, m_ol;
    logic [63:0] m_od;
    int          m_os;
    int          d_left [N];
    bit          d_val  [N];
    logic [63:0] d_data [N];

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_locked = 0; m_ov = 0; m_ol = 0; m_od = '0; m_os = 0;
        for (int i = 0; i < N; i++) begin
            d_left[i] = 0; d_val[i] = 0; d_data[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b1;
`ifdef CAM_SCHED_STATS_EN
        stat_clr = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic        ordy;
        logic [63:0] d2;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_src;
        logic        e_last;
        logic [63:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t vt [10];

    initial begin
        logic [N-1:0] mrdy;
        bit           acc, found;
        int           nb;

        w_rst_n = 1'b0; w_req_valid = '0; w_req_last = '0; w_req_data = '0; w_out_ready = 1'b1;
`ifdef CAM_SCHED_STATS_EN
        w_stat_clr = 1'b0;
`endif

        // Requester 1 single beat, then requester 2 three beats while 1 waits.
        vt[0] = '{4'b0010, 4'b0010, 1'b1, 64'h0,   4'b0000, 1'b0, 2'd0, 1'b0, 64'h0,    1'b0};
        vt[1] = '{4'b0010, 4'b0010, 1'b1, 64'h0,   4'b0010, 1'b0, 2'd0, 1'b0, 64'h0,    1'b1};
        vt[2] = '{4'b0110, 4'b0010, 1'b1, 64'h0,   4'b0000, 1'b1, 2'd1, 1'b1, 64'h1111, 1'b1};
        vt[3] = '{4'b0110, 4'b0010, 1'b1, 64'hA,   4'b0100, 1'b0, 2'd0, 1'b0, 64'h0,    1'b1};
        vt[4] = '{4'b0110, 4'b0010, 1'b1, 64'hB,   4'b0100, 1'b1, 2'd2, 1'b0, 64'hA,    1'b1};
        vt[5] = '{4'b0110, 4'b0110, 1'b1, 64'hC,   4'b0100, 1'b1, 2'd2, 1'b0, 64'hB,    1'b1};
        vt[6] = '{4'b0010, 4'b0010, 1'b1, 64'h0,   4'b0000, 1'b1, 2'd2, 1'b1, 64'hC,    1'b1};
        vt[7] = '{4'b0010, 4'b0010, 1'b1, 64'h0,   4'b0010, 1'b0, 2'd0, 1'b0, 64'h0,    1'b1};
        vt[8] = '{4'b0000, 4'b0000, 1'b1, 64'h0,   4'b0000, 1'b1, 2'd1, 1'b1, 64'h1111, 1'b1};
        vt[9] = '{4'b0000, 4'b0000, 1'b1, 64'h0,   4'b0000, 1'b0, 2'd0, 1'b0, 64'h0,    1'b0};

        do_reset();
        req_data[DW +: DW] = 64'h1111;
        for (int r = 0; r < 10; r++) begin
            req_valid = vt[r].vld; req_last = vt[r].lst; out_ready = vt[r].ordy;
            req_data[2*DW +: DW] = vt[r].d2;
            #1;
            check($sformatf("tbl%0d_rdy", r), req_ready, vt[r].e_rdy);
            check($sformatf("tbl%0d_ov", r), out_valid, vt[r].e_ov);
            check($sformatf("tbl%0d_busy", r), busy, vt[r].e_busy);
            if (vt[r].e_ov) begin
                check($sformatf("tbl%0d_src", r), out_src, vt[r].e_src);
                check($sformatf("tbl%0d_last", r), out_last, vt[r].e_last);
                check($sformatf("tbl%0d_data", r), out_data, vt[r].e_data);
            end
            @(negedge clk);
        end

        // All four requesters with continuous single-beat transactions.
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 64'hA0 + 64'(i);
        req_valid = '1; req_last = '1; out_ready = 1'b1;
        nb = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (out_valid) begin
                check("rr_src", out_src, 64'(nb % 4));
                check("rr_cycle", 64'(c), 64'(2 + 2 * nb));
                check("rr_data", out_data, 64'hA0 + 64'(nb % 4));
                nb++;
            end
            @(negedge clk);
        end
        check("rr_beats", 64'(nb), 64'd9);

        // Weighted instance: requesters 0 and 1 always valid.
        w_req_valid = 4'b0011; w_req_last = 4'b1111; w_out_ready = 1'b1;
        @(negedge clk);
        w_rst_n = 1'b1;
        nb = 0;
        for (int c = 0; c < 34; c++) begin
            #1;
            if (w_out_valid) begin
                check("w_src", w_out_src, (nb % 4 == 3) ? 64'd1 : 64'd0);
                nb++;
            end
            @(negedge clk);
        end
        check("w_beats", 64'(nb), 64'd16);

        // Reset in the middle of a 4-beat transaction from requester 3.
        do_reset();
        req_data[DW +: DW] = 64'h55;
        req_valid = 4'b0010; req_last = 4'b0010;
        @(negedge clk); @(negedge clk);
        req_valid = 4'b1000; req_last = 4'b0000; req_data[3*DW +: DW] = 64'h300;
        @(negedge clk); @(negedge clk);
        req_data[3*DW +: DW] = 64'h301;
        @(negedge clk);
        #1;
        check("mid_src", out_src, 64'd3);
        check("mid_data", out_data, 64'h301);
        check("mid_rdy", req_ready, 64'b1000);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ov", out_valid, 64'd0);
        check("arst_data", out_data, 64'd0);
        check("arst_src", out_src, 64'd0);
        check("arst_last", out_last, 64'd0);
        check("arst_busy", busy, 64'd0);
        check("arst_rdy", req_ready, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1101; req_last = 4'b1111; req_data[0 +: DW] = 64'h400;
        @(negedge clk);
        #1 check("post_rst_rdy", req_ready, 64'b0001);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("post_rst_src", out_src, 64'd0);
        check("post_rst_data", out_data, 64'h400);
        @(negedge clk);

        // Random traffic against the reference model, with periodic output stalls.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!d_val[i] && $urandom_range(0, 3) == 0) begin
                    if (d_left[i] == 0) d_left[i] = $urandom_range(1, 4);
                    d_val[i]  = 1;
                    d_data[i] = {$urandom, $urandom};
                end
                req_valid[i] = d_val[i];
                if (d_val[i]) begin
                    req_last[i] = (d_left[i] == 1);
                    req_data[i*DW +: DW] = d_data[i];
                end else begin
                    req_last[i] = 1'($urandom);
                    req_data[i*DW +: DW] = {$urandom, $urandom};
                end
            end
            out_ready = (cyc % 50 >= 20 && cyc % 50 < 25) ? 1'b0 : ($urandom_range(0, 3) != 0);
            #1;
            mrdy = '0;
            if (m_locked && (!m_ov || out_ready)) mrdy[m_owner] = 1'b1;
            check("rnd_rdy", req_ready, mrdy);
            check("rnd_ov", out_valid, m_ov);
            check("rnd_busy", busy, m_locked || m_ov);
            if (m_ov) begin
                check("rnd_data", out_data, m_od);
                check("rnd_last", out_last, m_ol);
                check("rnd_src", out_src, 64'(m_os));
            end
            @(posedge clk);
            acc = m_locked && req_valid[m_owner] && mrdy[m_owner];
            if (acc) begin
                m_ov = 1; m_od = req_data[m_owner*DW +: DW]; m_ol = req_last[m_owner]; m_os = m_owner;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (!m_locked) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req_valid[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        found = 1;
                    end
                end
                m_locked = found;
            end else if (acc && req_last[m_owner]) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && mrdy[i]) begin
                    d_left[i]--;
                    d_val[i] = 0;
                end
            end
            @(negedge clk);
        end

`ifdef CAM_SCHED_STATS_EN
        do_reset();
        req_data[DW +: DW] = 64'h77;
        req_valid = 4'b0010; req_last = 4'b0010;
        repeat (6) @(negedge clk);
        check("stat_r1_three", stat_txn[31:16], 64'd3);
        check("stat_r0_zero", stat_txn[15:0], 64'd0);
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        req_valid = '0;
        #1 check("stat_clr_wins", stat_txn[31:16], 64'd0);
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
